// File: rtl/seq_u_csks24.sv
// seq_u_csks24: sequential 24-bit unsigned carry-skip subtractor.
// Computes a - b as a + ~b + 1, one 4-bit skip block per clock, and returns
// {borrow, difference} behind valid/ready handshakes on both sides.
// Optional build macro: CSKS_SKIP_EN -- when a block fully propagates, the next
// block is processed in the same cycle (dual-block step). Results are identical
// in both builds; only latency changes.
module seq_u_csks24 #(
    parameter int N   = 24,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out
);

    localparam int NB = N / BLK;
    localparam int IW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   a_q, b_q;
    logic [N:0]     out_q;
    logic           carry_q;
    logic [IW-1:0]  idx_q;

    logic           accept;
    logic           last;
    logic           dual;
    logic           c_next;
    int             idx_adv;
    logic [BLK-1:0] a0, b0, d0;
    logic           c0;
`ifdef CSKS_SKIP_EN
    logic [BLK-1:0] a1, b1, d1;
    logic           c1;
`endif

    // One skip block of a + ~b + cin: returns {carry_out, difference bits}.
    // A fully propagating block forwards its carry-in straight to its carry-out.
    function automatic logic [BLK:0] sub_blk(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           cin);
        logic [BLK-1:0] p, g, d;
        logic           c;
        p = ~(x ^ y);
        g = x & ~y;
        c = cin;
        for (int i = 0; i < BLK; i++) begin
            d[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {(&p) ? cin : c, d};
    endfunction

    assign accept = (state_q == IDLE) && in_valid;
    assign out    = out_q;

    // Select the operand slice(s) at the current block index and evaluate them.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through this block can leave a value unassigned and infer a latch.
        a0 = '0;
        b0 = '0;
        for (int j = 0; j < NB; j++) begin
            if (int'(idx_q) == j) begin
                a0 = a_q[j*BLK +: BLK];
                b0 = b_q[j*BLK +: BLK];
            end
        end
        {c0, d0} = sub_blk(a0, b0, carry_q);
`ifdef CSKS_SKIP_EN
        a1 = '0;
        b1 = '0;
        for (int j = 0; j < NB; j++) begin
            if (int'(idx_q) + 1 == j) begin
                a1 = a_q[j*BLK +: BLK];
                b1 = b_q[j*BLK +: BLK];
            end
        end
        // Second block is only taken when the first one propagates, so its
        // carry-in (c0) equals the incoming carry.
        {c1, d1} = sub_blk(a1, b1, c0);
        dual     = (a0 == b0) && (int'(idx_q) + 1 < NB);
        c_next   = dual ? c1 : c0;
`else
        dual     = 1'b0;
        c_next   = c0;
`endif
        idx_adv = int'(idx_q) + (dual ? 2 : 1);
        last    = (idx_adv >= NB);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state and handshake decode; outputs depend on state only.
    always_comb begin
        state_n   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture operands at accept, then write one (or two) blocks per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            out_q   <= '0;
            carry_q <= 1'b1;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            for (int j = 0; j < NB; j++) begin
                if (int'(idx_q) == j) out_q[j*BLK +: BLK] <= d0;
`ifdef CSKS_SKIP_EN
                if (dual && (int'(idx_q) + 1 == j)) out_q[j*BLK +: BLK] <= d1;
`endif
            end
            carry_q <= c_next;
            idx_q   <= IW'(idx_adv);
            if (last) out_q[N] <= ~c_next;
        end
    end

endmodule

// File: tb/tb_seq_u_csks24.sv
// Self-checking bench for seq_u_csks24: directed cases, backpressure, mid-run
// reset and 2000 random transactions against a behavioural reference model.
// Honours CSKS_SKIP_EN for the expected latency.
module tb_seq_u_csks24;

    localparam int N   = 24;
    localparam int BLK = 4;
    localparam int NB  = N / BLK;
`ifdef CSKS_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N:0]   out_w;

    int n_vec  = 0;
    int n_miss = 0;

    seq_u_csks24 #(.N(N), .BLK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: borrow is simply a<b; difference is modular subtraction.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] d;
        d = x - y;
        return {x < y, d};
    endfunction

    // Reference latency: one cycle per step; with skipping, an equal block
    // (all bits propagate) that is not the last lets the step cover two blocks.
    function automatic int ref_lat(input logic [N-1:0] x, input logic [N-1:0] y);
        int i = 0;
        int c = 0;
        while (i < NB) begin
            if (SKIP && (x[i*BLK +: BLK] == y[i*BLK +: BLK]) && (i + 1 < NB)) i += 2;
            else i += 1;
            c++;
        end
        return c;
    endfunction

    // Full transaction: accept, wait for result, stall, then hand off.
    task automatic run_txn(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           input int stall, input bit junk);
        logic [N:0] exp;
        int         lat;
        exp = ref_sub(ta, tb_v);
        @(negedge clk);
        check("in_ready_idle", (N+1)'(in_ready), (N+1)'(1));
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        lat      = 0;
        while (!out_valid && lat < NB + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", (N+1)'(out_valid), (N+1)'(1));
        check("latency", (N+1)'(lat), (N+1)'(ref_lat(ta, tb_v)));
        check("result", out_w, exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = junk;
            a        = N'($urandom);
            b        = N'($urandom);
            @(posedge clk);
            #1;
            check("hold_out", out_w, exp);
            check("hold_in_ready", (N+1)'(in_ready), (N+1)'(0));
            check("hold_valid", (N+1)'(out_valid), (N+1)'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", (N+1)'(out_valid), (N+1)'(0));
        check("post_in_ready", (N+1)'(in_ready), (N+1)'(1));
    endtask

    initial begin
        // Reset state, checked while reset is held and after release.
        #12;
        check("rst_in_ready", (N+1)'(in_ready), (N+1)'(1));
        check("rst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        check("rst_out", out_w, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_out", out_w, '0);
        check("rel_out_valid", (N+1)'(out_valid), (N+1)'(0));

        // Directed cases.
        run_txn(24'h000005, 24'h000003, 0, 1'b0);
        run_txn(24'h000000, 24'h000001, 0, 1'b0);
        run_txn(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0);
        run_txn(24'h000000, 24'h000000, 1, 1'b0);
        run_txn(24'hFFFFFF, 24'h000000, 0, 1'b0);

        // Backpressure with new operands offered throughout the stall.
        run_txn(24'h123456, 24'h012345, 10, 1'b1);
        // Explicit value check of the backpressure case.
        check("bp_const", ref_sub(24'h123456, 24'h012345), 25'h0111111);

        // Reset in the third RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 24'h800000;
        b        = 24'h000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        check("midrst_out", out_w, '0);
        check("midrst_in_ready", (N+1)'(in_ready), (N+1)'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(24'h000010, 24'h000010, 0, 1'b0);

        // Random back-to-back traffic with random consumer stalls.
        for (int t = 0; t < 2000; t++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = N'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ N'(24'h00F000 << (4 * $urandom_range(0, 2)));
                default: ;
            endcase
            run_txn(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
